// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared definitions for the load/store-multiple sequencer.
//   state_t      : sequencer states (IDLE, XFER, WB, FIN)
//   IR_*         : bit positions of the fields latched from the instruction word
//   WORD_STEP    : byte distance between consecutive transfers
package ldm_stm_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WB   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam int IR_P_BIT    = 24;  // 1 = pre-index (before), 0 = post-index (after)
    localparam int IR_U_BIT    = 23;  // 1 = increment, 0 = decrement
    localparam int IR_W_BIT    = 21;  // base writeback
    localparam int IR_L_BIT    = 20;  // 1 = load (LDM), 0 = store (STM)
    localparam int IR_RN_LSB   = 16;
    localparam int IR_RN_W     = 4;
    localparam int IR_LIST_LSB = 0;
    localparam int WORD_STEP   = 4;

endpackage

// File: rtl/ldm_stm_sequencer_lowest_set_bit16.sv
// Combinational priority encoder: index of the lowest set bit of a 16-bit list.
//   list  : input register list
//   index : position of the lowest set bit (0 when list is empty)
//   valid : list has at least one bit set
module lowest_set_bit16 (
    input  logic [15:0] list,
    output logic [3:0]  index,
    output logic        valid
);

    always_comb begin
        index = '0;
        valid = |list;
        // Scan from the top so the lowest set bit is the last one written.
        for (int i = 15; i >= 0; i--) begin
            if (list[i]) index = 4'(i);
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Load/Store Multiple sequencer. Latches the instruction fields, base and
// byte count on START, then issues one memory transfer per MOC handshake,
// lowest register first at ascending addresses, optionally followed by a
// base writeback and a one-cycle DONE.
//   CLK, RESET            : clock, asynchronous active-high reset
//   START, IR, BASE, OFFSET: request and its operands (sampled in IDLE)
//   MOC                   : memory operation complete for the current transfer
//   MEM_EN/RW/ADDR        : memory request, direction (1 = read), word address
//   REG_SEL, REG_LOAD     : register index and load strobe (LDM only)
//   WB_EN, WB_VALUE       : base writeback strobe and value
//   BUSY, DONE            : not-idle flag, completion pulse
module ldm_stm_sequencer
    import ldm_stm_sequencer_pkg::*;
#(
    parameter int NREG   = 16,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [31:0]       IR,
    input  logic [ADDR_W-1:0] BASE,
    input  logic [ADDR_W-1:0] OFFSET,
    input  logic              MOC,
    output logic              MEM_EN,
    output logic              MEM_RW,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [3:0]        REG_SEL,
    output logic              REG_LOAD,
    output logic              WB_EN,
    output logic [ADDR_W-1:0] WB_VALUE,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_STEP);

    state_t            state;
    logic [NREG-1:0]   pend;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] wb_val;
    logic              rw, wb, wb_sup;
    logic              mem_en, busy, wb_en, done;

    logic [3:0]        sel;
    logic              sel_vld;
    logic [NREG-1:0]   pend_next;

    logic [NREG-1:0]   ir_list;
    logic              ir_p, ir_u;
    logic [ADDR_W-1:0] lo_addr, start_addr;
    logic              unused_ir;

    assign unused_ir = ^{IR[31:25], IR[22]};

    lowest_set_bit16 u_lsb (
        .list  (pend),
        .index (sel),
        .valid (sel_vld)
    );

    assign pend_next = pend & ~(NREG'(1) << sel);

    assign ir_list = IR[IR_LIST_LSB +: NREG];
    assign ir_p    = IR[IR_P_BIT];
    assign ir_u    = IR[IR_U_BIT];
    assign lo_addr = BASE - OFFSET;

    // Transfers always ascend; decrementing modes start from the low end.
    always_comb begin
        unique case ({ir_p, ir_u})
            2'b01:   start_addr = BASE;            // IA
            2'b11:   start_addr = BASE + STEP;     // IB
            2'b00:   start_addr = lo_addr + STEP;  // DA
            default: start_addr = lo_addr;         // DB
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= S_IDLE;
            pend   <= '0;
            addr   <= '0;
            wb_val <= '0;
            rw     <= 1'b0;
            wb     <= 1'b0;
            wb_sup <= 1'b0;
            mem_en <= 1'b0;
            busy   <= 1'b0;
            wb_en  <= 1'b0;
            done   <= 1'b0;
        end else begin
            wb_en <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (START) begin
                        pend   <= ir_list;
                        addr   <= start_addr;
                        wb_val <= ir_u ? BASE + OFFSET : lo_addr;
                        rw     <= IR[IR_L_BIT];
                        wb     <= IR[IR_W_BIT];
                        // A loaded Rn overrides the writeback.
                        wb_sup <= IR[IR_L_BIT] & ir_list[IR[IR_RN_LSB +: IR_RN_W]];
                        busy   <= 1'b1;
                        if (|ir_list) begin
                            state  <= S_XFER;
                            mem_en <= 1'b1;
                        end else begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                S_XFER: begin
                    if (MOC && sel_vld) begin
                        pend <= pend_next;
                        addr <= addr + STEP;
                        if (pend_next == '0) begin
                            mem_en <= 1'b0;
                            if (wb) begin
                                state <= S_WB;
                                wb_en <= ~wb_sup;
                            end else begin
                                state <= S_FIN;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                S_WB: begin
                    state <= S_FIN;
                    done  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign MEM_EN   = mem_en;
    assign MEM_RW   = rw;
    assign MEM_ADDR = addr;
    assign REG_SEL  = sel;
    // Strobe coincides with the handshake so REG_SEL still names the target.
    assign REG_LOAD = (state == S_XFER) && MOC && rw;
    assign WB_EN    = wb_en;
    assign WB_VALUE = wb_val;
    assign BUSY     = busy;
    assign DONE     = done;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
module tb_ldm_stm_sequencer;

    localparam int K_XFER = 0;
    localparam int K_WB   = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        rw;
        logic [31:0] val;
    } ev_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [31:0] IR = '0;
    logic [31:0] BASE = '0;
    logic [31:0] OFFSET = '0;
    logic        MOC = 1'b0;
    logic        MEM_EN, MEM_RW, REG_LOAD, WB_EN, BUSY, DONE;
    logic [31:0] MEM_ADDR, WB_VALUE;
    logic [3:0]  REG_SEL;

    int  n_checks = 0;
    int  n_errors = 0;
    ev_t q[$];

    ldm_stm_sequencer #(.NREG(16), .ADDR_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .IR(IR), .BASE(BASE),
        .OFFSET(OFFSET), .MOC(MOC), .MEM_EN(MEM_EN), .MEM_RW(MEM_RW),
        .MEM_ADDR(MEM_ADDR), .REG_SEL(REG_SEL), .REG_LOAD(REG_LOAD),
        .WB_EN(WB_EN), .WB_VALUE(WB_VALUE), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic bad(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    function automatic logic [31:0] mk_ir(input bit p, u, w, l, input logic [3:0] rn,
                                          input logic [15:0] list);
        return {4'hE, 3'b100, p, u, 1'b0, w, l, rn, list};
    endfunction

    // Reference model: expected transfers, writeback and completion for one op.
    task automatic push_op(input logic [31:0] ir, base, off);
        bit p, u, w, l;
        logic [15:0] list;
        logic [31:0] a;
        ev_t e;
        p = ir[24]; u = ir[23]; w = ir[21]; l = ir[20]; list = ir[15:0];
        if (list != 0) begin
            if (u) a = p ? base + 4 : base;
            else   a = p ? base - off : base - off + 4;
            for (int i = 0; i < 16; i++) begin
                if (list[i]) begin
                    e = '{kind: K_XFER, addr: a, sel: 4'(i), rw: l, val: 0};
                    q.push_back(e);
                    a = a + 4;
                end
            end
            if (w && !(l && list[ir[19:16]])) begin
                e = '{kind: K_WB, addr: 0, sel: 0, rw: 0, val: u ? base + off : base - off};
                q.push_back(e);
            end
        end
        e = '{kind: K_DONE, addr: 0, sel: 0, rw: 0, val: 0};
        q.push_back(e);
    endtask

    // Monitor: compares whatever the DUT presents against the queue head.
    always @(negedge CLK) begin
        ev_t e;
        if (!RESET) begin
            if (MEM_EN) begin
                if (q.size() == 0 || q[0].kind != K_XFER) bad("unexpected_xfer");
                else begin
                    e = q[0];
                    chk("mem_addr", MEM_ADDR, e.addr);
                    chk("reg_sel", 32'(REG_SEL), 32'(e.sel));
                    chk("mem_rw", 32'(MEM_RW), 32'(e.rw));
                    if (MOC) begin
                        chk("reg_load", 32'(REG_LOAD), 32'(e.rw));
                        void'(q.pop_front());
                    end else chk("reg_load_stall", 32'(REG_LOAD), 0);
                end
            end else chk("reg_load_noxfer", 32'(REG_LOAD), 0);
            if (WB_EN) begin
                if (q.size() == 0 || q[0].kind != K_WB) bad("unexpected_wb");
                else begin
                    e = q.pop_front();
                    chk("wb_value", WB_VALUE, e.val);
                end
            end
            if (DONE) begin
                if (q.size() == 0 || q[0].kind != K_DONE) bad("unexpected_done");
                else void'(q.pop_front());
            end
        end
    end

    task automatic chk_all_zero(input string nm);
        chk({nm, "_mem_en"}, 32'(MEM_EN), 0);
        chk({nm, "_mem_rw"}, 32'(MEM_RW), 0);
        chk({nm, "_mem_addr"}, MEM_ADDR, 0);
        chk({nm, "_reg_sel"}, 32'(REG_SEL), 0);
        chk({nm, "_reg_load"}, 32'(REG_LOAD), 0);
        chk({nm, "_wb_en"}, 32'(WB_EN), 0);
        chk({nm, "_wb_value"}, WB_VALUE, 0);
        chk({nm, "_busy"}, 32'(BUSY), 0);
        chk({nm, "_done"}, 32'(DONE), 0);
    endtask

    // mode 0: MOC always high; 1: random MOC; 2: stall second transfer 3 cycles
    task automatic run_op(input logic [31:0] ir, base, off, input int mode, input bit busy_start);
        int cnt, hs, stall, n, exp_cnt;
        cnt = 0;
        while (BUSY && cnt < 100) begin @(posedge CLK); #1; cnt++; end
        if (BUSY) bad("wait_idle_timeout");
        push_op(ir, base, off);
        IR = ir; BASE = base; OFFSET = off; START = 1'b1;
        MOC = (mode == 0);  // MOC alongside START in IDLE must be ignored
        @(posedge CLK); #1;
        START = busy_start;
        if (busy_start) begin
            IR = mk_ir(0, 1, 1, 1, 4'd0, 16'hFFFF);
            BASE = ~base;
        end
        cnt = 1; hs = 0; stall = 0;
        while (!DONE && cnt < 300) begin
            if (mode == 0) MOC = 1'b1;
            else if (mode == 1) MOC = ($urandom_range(0, 2) != 0);
            else if (MEM_EN && hs == 1 && stall < 3) begin MOC = 1'b0; stall++; end
            else begin MOC = 1'b1; if (MEM_EN) hs++; end
            @(posedge CLK); #1;
            START = 1'b0;
            cnt++;
        end
        if (!DONE) bad("done_timeout");
        n = $countones(ir[15:0]);
        exp_cnt = (n == 0) ? 1 : n + int'(ir[21]) + 1 + ((mode == 2) ? 3 : 0);
        if (mode != 1) chk("done_cycles", cnt, exp_cnt);
        @(posedge CLK); #1;
        START = 1'b0; MOC = 1'b0;
        chk("idle_after_done", 32'(BUSY), 0);
    endtask

    task automatic reset_mid_op();
        logic [31:0] ir;
        int cnt;
        cnt = 0;
        while (BUSY && cnt < 100) begin @(posedge CLK); #1; cnt++; end
        ir = mk_ir(0, 1, 1, 1, 4'd9, 16'h0007);
        push_op(ir, 32'h5000, 32'd12);
        IR = ir; BASE = 32'h5000; OFFSET = 32'd12; START = 1'b1; MOC = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;              // first transfer on the bus this cycle
        @(posedge CLK); #1;        // second transfer
        chk("pre_reset_sel", 32'(REG_SEL), 1);
        #1 RESET = 1'b1;
        #1 chk_all_zero("async_reset");
        q.delete();
        @(posedge CLK); #1;
        chk_all_zero("held_reset");
        RESET = 1'b0; MOC = 1'b0;
    endtask

    initial begin
        logic [31:0] ir, base;
        logic [15:0] list;
        #2 chk_all_zero("reset");
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        // LDMIA W=1
        run_op(mk_ir(0, 1, 1, 1, 4'd1, 16'h0005), 32'h1000, 32'd8, 0, 0);
        // STMDB W=1
        run_op(mk_ir(1, 0, 1, 0, 4'd2, 16'hC001), 32'h2000, 32'd12, 0, 0);
        // LDMIB with Rn in list: writeback suppressed
        run_op(mk_ir(1, 1, 1, 1, 4'd3, 16'h0008), 32'h3000, 32'd4, 0, 0);
        // stall on the second transfer
        run_op(mk_ir(0, 1, 0, 1, 4'd0, 16'h00F0), 32'h4000, 32'd16, 2, 0);
        // empty list, with a START issued while busy
        run_op(mk_ir(0, 1, 1, 1, 4'd0, 16'h0000), 32'h6000, 32'd0, 0, 1);
        // START while busy on a non-empty list
        run_op(mk_ir(1, 1, 1, 0, 4'd4, 16'h0102), 32'h7000, 32'd8, 0, 1);
        reset_mid_op();
        // clean sequence after reset
        run_op(mk_ir(0, 1, 1, 1, 4'd1, 16'h0005), 32'h1000, 32'd8, 0, 0);
        // LDMDA with wrap-around
        run_op(mk_ir(0, 0, 0, 1, 4'd5, 16'h0003), 32'h0000_0004, 32'd8, 0, 0);
        // all registers, decrement from near zero
        run_op(mk_ir(1, 0, 1, 0, 4'd0, 16'hFFFF), 32'h0000_0010, 32'd64, 0, 0);
        for (int k = 0; k < 40; k++) begin
            list = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 7) == 0) list = 16'h0000;
            ir = mk_ir(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       4'($urandom), list);
            base = $urandom;
            run_op(ir, base, 32'($countones(list)) * 4, int'($urandom_range(0, 1)), 1'($urandom));
        end
        repeat (2) @(posedge CLK);
        #1 chk("scoreboard_drained", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
- Multicycle sequencer for Load/Store Multiple (IR[27:25]=100). It sits directly downstream of the shifter.
- Consumes the shifter's byte count (4 × number of registers in the list) together with the base register value Rn.
- Steps through the register list one transfer per memory handshake, driving address, direction and register index.
- Issues the base-register writeback value at the end.

Parameters:
- NREG, 16, width of the register list; also the number of architectural registers.
- ADDR_W, 32, width of addresses and data values.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle request to begin a block transfer; sampled only in IDLE.
- IR  in  32  instruction word, sampled at START.
- BASE  in  ADDR_W  value of Rn, sampled at START.
- OFFSET  in  ADDR_W  shifter operand (4 × popcount(IR[15:0])), sampled at START.
- MOC  in  1  memory operation complete for the current transfer.
- MEM_EN  out  1  memory request active.
- MEM_RW  out  1  1 = read (LDM), 0 = write (STM); equals latched IR[20].
- MEM_ADDR  out  ADDR_W  word address of the current transfer.
- REG_SEL  out  4  register index being transferred.
- REG_LOAD  out  1  one-cycle register-file write strobe (LDM only).
- WB_EN  out  1  one-cycle Rn writeback strobe.
- WB_VALUE  out  ADDR_W  new Rn value.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state = IDLE. All outputs are 0, and all latched registers (list, address, IR fields) are 0. Reset asserted mid-transfer aborts immediately: no REG_LOAD, no WB_EN, no DONE.
- Fields latched at START: P=IR[24], U=IR[23], W=IR[21], L=IR[20], Rn=IR[19:16], list=IR[15:0].
- Start address, mod 2^32 with wrap-around permitted:
  - IA (P=0,U=1): BASE.
  - IB (P=1,U=1): BASE+4.
  - DA (P=0,U=0): BASE−OFFSET+4.
  - DB (P=1,U=0): BASE−OFFSET.
- Writeback value: U ? BASE+OFFSET : BASE−OFFSET. It is computed at START and held.
- States:
  - IDLE: START=1 latches the fields. A non-empty list goes to XFER; an empty list goes straight to FIN (no transfers, no writeback).
  - XFER: MEM_EN=1, MEM_ADDR=current address, REG_SEL = lowest set bit of the pending list.
    - While MOC=0, hold every output stable.
    - On MOC=1: clear that bit, advance the address by 4, and pulse REG_LOAD in the same cycle if L=1.
    - If the pending list is now empty, go to WB when W=1, else FIN. Otherwise stay in XFER with the next index.
    - Addresses always ascend, and registers go lowest index first.
  - WB: WB_EN=1 for one cycle, then FIN. WB_EN is suppressed (still passing through WB) when L=1 and bit Rn of the original list is set, so the loaded value wins.
  - FIN: DONE=1 for one cycle, then IDLE.
- Timing: a START accepted at edge N puts XFER on the bus in cycle N+1. With MOC tied high, one register per cycle. Total cycles from START to DONE = n + (W?1:0) + 1.
- START while BUSY is ignored. START and MOC in the same IDLE cycle: MOC is ignored.
- MEM_EN is deasserted in WB, FIN and IDLE. MEM_RW is held at L throughout BUSY.
- OFFSET is trusted as given; the sequencer terminates on the list becoming empty, not on OFFSET.

Decomposition:
- Shared package: state encoding (IDLE, XFER, WB, FIN), IR field bit positions (P, U, W, L, Rn, list), word-step constant 4.
- Sub-module lowest_set_bit16: combinational priority encoder. Input is the 16-bit list; outputs are the 4-bit index and a valid bit. It is instantiated once for REG_SEL.

Test Plan:
1. LDMIA, BASE=0x1000, list=0x0005, W=1, MOC=1 → REG_SEL 0 then 2 at 0x1000, 0x1004; two REG_LOAD pulses; WB_VALUE=0x1008; DONE on cycle 4 after START.
2. STMDB, BASE=0x2000, list=0xC001, OFFSET=12, W=1 → REG_SEL 0, 14, 15 at 0x1FF4, 0x1FF8, 0x1FFC; MEM_RW=0; WB_VALUE=0x1FF4.
3. LDMIB, Rn=3, list=0x0008, W=1 → one transfer at BASE+4; WB_EN never asserted; DONE asserted.
4. MOC held low 3 cycles on the second transfer → MEM_ADDR and REG_SEL stable for those cycles; no extra REG_LOAD.
5. Empty list → no MEM_EN; DONE one cycle after START. Second START issued while BUSY → ignored.
6. RESET asserted during the second transfer → all outputs 0 asynchronously; the next START runs a clean sequence.
7. LDMDA, BASE=0x0000_0004, OFFSET=8, list=0x0003 → addresses 0x0000_0000 and 0x0000_0004, exercising the DA start formula with wrap-around arithmetic.
